// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the EX-stage hazard/forwarding unit: select encoding,
// scoreboard slot layouts and the register-hit helper.
package hazard_forward_unit_pkg;

    localparam int LEN_REG_ADDR = 4;
    localparam int LEN_FORW_SEL = 2;

    localparam logic [LEN_FORW_SEL-1:0] FORW_SEL_FROM_ID  = 2'd0;
    localparam logic [LEN_FORW_SEL-1:0] FORW_SEL_FROM_MEM = 2'd1;
    localparam logic [LEN_FORW_SEL-1:0] FORW_SEL_FROM_WB  = 2'd2;

`define HFU_EX_SLOT_W  16
`define HFU_MEM_SLOT_W 6
`define HFU_WB_SLOT_W  5

    typedef logic [LEN_REG_ADDR-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t src1;
        reg_addr_t src2;
        logic      use1;
        logic      use2;
        reg_addr_t dest;
        logic      wb_en;
        logic      mem_read;
    } ex_slot_t;

    typedef struct packed {
        reg_addr_t dest;
        logic      wb_en;
        logic      mem_read;
    } mem_slot_t;

    typedef struct packed {
        reg_addr_t dest;
        logic      wb_en;
    } wb_slot_t;

    function automatic logic reg_hit(
        input logic      use_src,
        input reg_addr_t src,
        input reg_addr_t dest,
        input logic      wb_en
    );
        return use_src && wb_en && (src == dest);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_forward_select.sv
// Per-operand bypass mux select: the younger MEM write beats the older WB write.
// Only built when FORWARDING_EN is defined.
module forward_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = LEN_REG_ADDR,
    parameter int FORW_W     = LEN_FORW_SEL
) (
    input  logic [REG_ADDR_W-1:0] ex_src_i,
    input  logic                  ex_use_i,
    input  logic [REG_ADDR_W-1:0] mem_dest_i,
    input  logic                  mem_wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_dest_i,
    input  logic                  wb_wb_en_i,
    output logic [FORW_W-1:0]     sel_o
);

    always_comb begin
        sel_o = FORW_W'(FORW_SEL_FROM_ID);
        if (ex_use_i && mem_wb_en_i && (mem_dest_i == ex_src_i)) begin
            sel_o = FORW_W'(FORW_SEL_FROM_MEM);
        end else if (ex_use_i && wb_wb_en_i && (wb_dest_i == ex_src_i)) begin
            sel_o = FORW_W'(FORW_SEL_FROM_WB);
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage hazard detection over an EX/MEM/WB scoreboard of in-flight writes.
// Define FORWARDING_EN to build the MEM/WB bypass; otherwise every RAW stalls.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = LEN_REG_ADDR,
    parameter int FORW_W     = LEN_FORW_SEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    output logic                  hazard_stall,
    output logic [FORW_W-1:0]     forw_sel_op1,
    output logic [FORW_W-1:0]     forw_sel_op2
);

    ex_slot_t  ex_q, ex_d;
    mem_slot_t mem_q, mem_d;
    wb_slot_t  wb_q, wb_d;
    logic      hit_ex;
    logic      raw_stall;
    logic      unused_slot_bits;

    assign hit_ex = id_valid &&
        (reg_hit(id_use_src1, id_src1, ex_q.dest, ex_q.wb_en) ||
         reg_hit(id_use_src2, id_src2, ex_q.dest, ex_q.wb_en));

`ifdef FORWARDING_EN
    // ALU results bypass from MEM/WB; only a load in EX cannot be served yet.
    assign raw_stall = hit_ex && ex_q.mem_read;

    forward_select #(
        .REG_ADDR_W (REG_ADDR_W),
        .FORW_W     (FORW_W)
    ) u_fwd_op1 (
        .ex_src_i    (ex_q.src1),
        .ex_use_i    (ex_q.use1),
        .mem_dest_i  (mem_q.dest),
        .mem_wb_en_i (mem_q.wb_en),
        .wb_dest_i   (wb_q.dest),
        .wb_wb_en_i  (wb_q.wb_en),
        .sel_o       (forw_sel_op1)
    );

    forward_select #(
        .REG_ADDR_W (REG_ADDR_W),
        .FORW_W     (FORW_W)
    ) u_fwd_op2 (
        .ex_src_i    (ex_q.src2),
        .ex_use_i    (ex_q.use2),
        .mem_dest_i  (mem_q.dest),
        .mem_wb_en_i (mem_q.wb_en),
        .wb_dest_i   (wb_q.dest),
        .wb_wb_en_i  (wb_q.wb_en),
        .sel_o       (forw_sel_op2)
    );

    assign unused_slot_bits = mem_q.mem_read;
`else
    logic hit_mem;

    assign hit_mem = id_valid &&
        (reg_hit(id_use_src1, id_src1, mem_q.dest, mem_q.wb_en) ||
         reg_hit(id_use_src2, id_src2, mem_q.dest, mem_q.wb_en));

    assign raw_stall    = hit_ex || hit_mem;
    assign forw_sel_op1 = FORW_W'(FORW_SEL_FROM_ID);
    assign forw_sel_op2 = FORW_W'(FORW_SEL_FROM_ID);

    assign unused_slot_bits = ^{ex_q.src1, ex_q.src2, ex_q.use1,
                                ex_q.use2, mem_q.mem_read, wb_q};
`endif

    // A flushed ID instruction never issues, so it cannot stall anything.
    assign hazard_stall = raw_stall && !flush;

    always_comb begin
        ex_d = '0;
        if (id_valid && !raw_stall && !flush) begin
            ex_d.src1     = id_src1;
            ex_d.src2     = id_src2;
            ex_d.use1     = id_use_src1;
            ex_d.use2     = id_use_src2;
            ex_d.dest     = id_dest;
            ex_d.wb_en    = id_wb_en;
            ex_d.mem_read = id_mem_read;
        end
        mem_d.dest     = ex_q.dest;
        mem_d.wb_en    = ex_q.wb_en;
        mem_d.mem_read = ex_q.mem_read;
        wb_d.dest      = mem_q.dest;
        wb_d.wb_en     = mem_q.wb_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios
// plus randomized traffic against an instruction-level pipeline model.
`timescale 1ns/1ps
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [1:0] S_ID  = FORW_SEL_FROM_ID;
    localparam logic [1:0] S_MEM = FORW_SEL_FROM_MEM;
    localparam logic [1:0] S_WB  = FORW_SEL_FROM_WB;

    typedef struct packed {
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       u1;
        logic       u2;
        logic [3:0] d;
        logic       wb;
        logic       ld;
    } inst_t;

    logic       clk = 1'b0;
    logic       rst, freeze, flush;
    logic       id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_read;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       hazard_stall;
    logic [1:0] forw_sel_op1, forw_sel_op2;

    int errors = 0;
    int checks = 0;

    inst_t idc, mex, mmem, mwb;

    hazard_forward_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use_src1  (id_use_src1),
        .id_use_src2  (id_use_src2),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_read  (id_mem_read),
        .hazard_stall (hazard_stall),
        .forw_sel_op1 (forw_sel_op1),
        .forw_sel_op2 (forw_sel_op2)
    );

    always #5 clk = ~clk;

    function automatic inst_t mk(input int s1, input bit u1, input int s2,
                                 input bit u2, input int d, input bit wb,
                                 input bit ld);
        inst_t i;
        i.v  = 1'b1;
        i.s1 = 4'(s1);
        i.u1 = u1;
        i.s2 = 4'(s2);
        i.u2 = u2;
        i.d  = 4'(d);
        i.wb = wb;
        i.ld = ld;
        return i;
    endfunction

    // An older instruction p supplies register src to a reader.
    function automatic bit supplies(input bit u, input logic [3:0] src, input inst_t p);
        return u && p.v && p.wb && (p.d == src);
    endfunction

    function automatic bit m_raw();
        bit on_ex, on_mem;
        on_ex  = idc.v && (supplies(idc.u1, idc.s1, mex) || supplies(idc.u2, idc.s2, mex));
        on_mem = idc.v && (supplies(idc.u1, idc.s1, mmem) || supplies(idc.u2, idc.s2, mmem));
        if (FWD) return on_ex && mex.ld;
        return on_ex || on_mem;
    endfunction

    function automatic logic [1:0] m_sel(input bit u, input logic [3:0] src);
        if (!FWD) return S_ID;
        if (supplies(u, src, mmem)) return S_MEM;
        if (supplies(u, src, mwb)) return S_WB;
        return S_ID;
    endfunction

    task automatic drive(input inst_t i);
        idc         = i;
        id_valid    = i.v;
        id_src1     = i.s1;
        id_src2     = i.s2;
        id_use_src1 = i.u1;
        id_use_src2 = i.u2;
        id_dest     = i.d;
        id_wb_en    = i.wb;
        id_mem_read = i.ld;
        #1;
    endtask

    task automatic tick();
        inst_t nex, nmem, nwb;
        nex  = mex;
        nmem = mmem;
        nwb  = mwb;
        if (rst) begin
            nex  = '0;
            nmem = '0;
            nwb  = '0;
        end else if (!freeze) begin
            nwb  = mmem;
            nmem = mex;
            nex  = '0;
            if (idc.v && !m_raw() && !flush) nex = idc;
        end
        @(posedge clk);
        mex  = nex;
        mmem = nmem;
        mwb  = nwb;
        #1;
    endtask

    // Present i in ID, hold it while stalled (bounded), then let it enter EX.
    task automatic issue(input inst_t i, output int n);
        n = 0;
        drive(i);
        while (hazard_stall && n < 4) begin
            tick();
            n++;
        end
        tick();
        drive('0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        drive('0);
        tick();
        rst = 1'b0;
        drive('0);
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        issue(mk(0, 0, 0, 0, 1, 1, 0), n);
        issue(mk(0, 0, 0, 0, 2, 1, 1), n);
        rst    = 1'b1;
        freeze = 1'b1;
        drive(mk(2, 1, 1, 1, 3, 1, 0));
        tick();
        rst    = 1'b0;
        freeze = 1'b0;
        drive(mk(2, 1, 1, 1, 3, 1, 0));
        checks++;
        if (hazard_stall !== 1'b0) begin
            $display("FAIL reset_stall: got %0b want 0", hazard_stall);
            errors++;
        end
        checks++;
        if (forw_sel_op1 !== S_ID) begin
            $display("FAIL reset_sel1: got %0d want %0d", forw_sel_op1, S_ID);
            errors++;
        end
        checks++;
        if (forw_sel_op2 !== S_ID) begin
            $display("FAIL reset_sel2: got %0d want %0d", forw_sel_op2, S_ID);
            errors++;
        end
        tick();
        drive('0);
        checks++;
        if (forw_sel_op1 !== S_ID || forw_sel_op2 !== S_ID) begin
            $display("FAIL reset_slots_cleared: got %0d/%0d want %0d/%0d",
                     forw_sel_op1, forw_sel_op2, S_ID, S_ID);
            errors++;
        end
    endtask

    task automatic test_alu_forward();
        int n;
        do_reset();
        issue(mk(0, 0, 0, 0, 1, 1, 0), n);
        issue(mk(1, 1, 3, 1, 2, 1, 0), n);
        checks++;
        if (n != (FWD ? 0 : 2)) begin
            $display("FAIL alu_stall_cycles: got %0d want %0d", n, FWD ? 0 : 2);
            errors++;
        end
        checks++;
        if (forw_sel_op1 !== (FWD ? S_MEM : S_ID)) begin
            $display("FAIL alu_sel1: got %0d want %0d", forw_sel_op1, FWD ? S_MEM : S_ID);
            errors++;
        end
        checks++;
        if (forw_sel_op2 !== S_ID) begin
            $display("FAIL alu_sel2: got %0d want %0d", forw_sel_op2, S_ID);
            errors++;
        end
    endtask

    task automatic test_load_use();
        int n;
        do_reset();
        issue(mk(0, 0, 0, 0, 4, 1, 1), n);
        issue(mk(4, 1, 4, 1, 5, 1, 0), n);
        checks++;
        if (n != (FWD ? 1 : 2)) begin
            $display("FAIL load_stall_cycles: got %0d want %0d", n, FWD ? 1 : 2);
            errors++;
        end
        checks++;
        if (forw_sel_op1 !== (FWD ? S_WB : S_ID)) begin
            $display("FAIL load_sel1: got %0d want %0d", forw_sel_op1, FWD ? S_WB : S_ID);
            errors++;
        end
        checks++;
        if (forw_sel_op2 !== (FWD ? S_WB : S_ID)) begin
            $display("FAIL load_sel2: got %0d want %0d", forw_sel_op2, FWD ? S_WB : S_ID);
            errors++;
        end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        issue(mk(0, 0, 0, 0, 6, 1, 0), n);
        issue(mk(0, 0, 0, 0, 6, 1, 0), n);
        issue(mk(6, 1, 7, 1, 8, 1, 0), n);
        checks++;
        if (forw_sel_op1 !== (FWD ? S_MEM : S_ID)) begin
            $display("FAIL prio_mem_over_wb: got %0d want %0d", forw_sel_op1, FWD ? S_MEM : S_ID);
            errors++;
        end
        checks++;
        if (forw_sel_op2 !== S_ID) begin
            $display("FAIL prio_unwritten_src: got %0d want %0d", forw_sel_op2, S_ID);
            errors++;
        end
        do_reset();
        issue(mk(0, 0, 0, 0, 6, 1, 0), n);
        issue(mk(0, 0, 0, 0, 6, 0, 0), n);
        issue(mk(6, 1, 7, 1, 8, 1, 0), n);
        checks++;
        if (forw_sel_op1 !== (FWD ? S_WB : S_ID)) begin
            $display("FAIL prio_mem_no_wb: got %0d want %0d", forw_sel_op1, FWD ? S_WB : S_ID);
            errors++;
        end
        checks++;
        if (forw_sel_op2 !== S_ID) begin
            $display("FAIL prio_mem_no_wb_op2: got %0d want %0d", forw_sel_op2, S_ID);
            errors++;
        end
    endtask

    task automatic test_flush();
        int n;
        do_reset();
        issue(mk(0, 0, 0, 0, 4, 1, 1), n);
        flush = 1'b1;
        drive(mk(4, 1, 4, 1, 5, 1, 0));
        checks++;
        if (hazard_stall !== 1'b0) begin
            $display("FAIL flush_beats_stall: got %0b want 0", hazard_stall);
            errors++;
        end
        tick();
        flush = 1'b0;
        issue(mk(5, 1, 0, 0, 7, 1, 0), n);
        checks++;
        if (n != 0) begin
            $display("FAIL flush_no_later_stall: got %0d want 0", n);
            errors++;
        end
        checks++;
        if (forw_sel_op1 !== S_ID) begin
            $display("FAIL flush_ex_bubble: got %0d want %0d", forw_sel_op1, S_ID);
            errors++;
        end
    endtask

    task automatic test_freeze();
        int n;
        do_reset();
        issue(mk(0, 0, 0, 0, 1, 1, 0), n);
        issue(mk(1, 1, 2, 0, 8, 1, 0), n);
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            drive('0);
            checks++;
            if (forw_sel_op1 !== (FWD ? S_MEM : S_ID)) begin
                $display("FAIL freeze_sel1[%0d]: got %0d want %0d", c, forw_sel_op1,
                         FWD ? S_MEM : S_ID);
                errors++;
            end
            checks++;
            if (forw_sel_op2 !== S_ID) begin
                $display("FAIL freeze_sel2[%0d]: got %0d want %0d", c, forw_sel_op2, S_ID);
                errors++;
            end
            checks++;
            if (hazard_stall !== 1'b0) begin
                $display("FAIL freeze_stall[%0d]: got %0b want 0", c, hazard_stall);
                errors++;
            end
        end
        freeze = 1'b0;
        issue(mk(1, 1, 8, 1, 9, 1, 0), n);
        checks++;
        if (forw_sel_op1 !== (FWD ? S_WB : S_ID)) begin
            $display("FAIL freeze_kept_wb: got %0d want %0d", forw_sel_op1, FWD ? S_WB : S_ID);
            errors++;
        end
        checks++;
        if (forw_sel_op2 !== (FWD ? S_MEM : S_ID)) begin
            $display("FAIL freeze_kept_mem: got %0d want %0d", forw_sel_op2, FWD ? S_MEM : S_ID);
            errors++;
        end
    endtask

    task automatic test_random();
        inst_t      r;
        bit         es;
        logic [1:0] e1, e2;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 49) == 0);
            freeze = ($urandom_range(0, 6) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            r.v  = ($urandom_range(0, 4) != 0);
            r.s1 = 4'($urandom_range(0, 3));
            r.s2 = 4'($urandom_range(0, 3));
            r.u1 = 1'($urandom_range(0, 1));
            r.u2 = 1'($urandom_range(0, 1));
            r.d  = 4'($urandom_range(0, 3));
            r.wb = ($urandom_range(0, 3) != 0);
            r.ld = ($urandom_range(0, 2) == 0);
            drive(r);
            es = m_raw() && !flush;
            e1 = m_sel(mex.u1, mex.s1);
            e2 = m_sel(mex.u2, mex.s2);
            checks++;
            if (hazard_stall !== es) begin
                $display("FAIL rand_stall[%0d]: got %0b want %0b", c, hazard_stall, es);
                errors++;
            end
            checks++;
            if (forw_sel_op1 !== e1) begin
                $display("FAIL rand_sel1[%0d]: got %0d want %0d", c, forw_sel_op1, e1);
                errors++;
            end
            checks++;
            if (forw_sel_op2 !== e2) begin
                $display("FAIL rand_sel2[%0d]: got %0d want %0d", c, forw_sel_op2, e2);
                errors++;
            end
            tick();
        end
        rst    = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        mex  = '0;
        mmem = '0;
        mwb  = '0;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_priority();
        test_flush();
        test_freeze();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
